fsk_bit_scheduler: RTL and testbench
====================================

Name: fsk_bit_scheduler

Overview:
- Controller that sequences the sine/DDS generator for 2-FSK transmission.
- Accepts 32-bit data words on an AXI4-Stream slave and serialises each word MSB-first.
- For each bit it drives the generator's frequency tuning word (FTW0 for bit 0, FTW1 for bit 1) for SAMPLES_PER_BIT generator sample strobes.
- Reports word completion upstream; a one-word holding register gives back-to-back, gap-free symbols across word boundaries.

Parameters:
SAMPLES_PER_BIT, 64, sample_en strobes per transmitted bit; legal range 2..65535.
FTW0, 32'h0147AE14, tuning word driven for a 0 bit.
FTW1, 32'h028F5C29, tuning word driven for a 1 bit.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
s_axis_tdata  in  32  data word; bit 31 is transmitted first.
s_axis_tkeep  in  4  byte enables; only 4'hF words are transmitted.
s_axis_tlast  in  1  marks the last word of a packet.
s_axis_tvalid  in  1  upstream word valid.
s_axis_tready  out  1  scheduler can accept a word.
sample_en  in  1  one-clock strobe per generator output sample.
ftw  out  32  tuning word for the generator.
ftw_valid  out  1  generator enable; high while a bit is being sent.
bit_out  out  1  bit currently being sent.
tx_pkt_done  out  1  one-clock pulse when a word's last bit completes.
tx_last  out  1  one-clock pulse, coincident with tx_pkt_done, when that word had tlast set.
word_cnt  out  16  count of words fully transmitted; wraps at 16'hFFFF -> 0.
state  out  1  0 = IDLE, 1 = SEND.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; shift register, hold register, hold_valid, bit_idx and sample_cnt cleared.
  - Outputs: s_axis_tready = 0 during reset, ftw_valid = 0, ftw = 0, bit_out = 0, tx_pkt_done = 0, tx_last = 0, word_cnt = 0.
  - Reset mid-word: the word and any held word are dropped silently, with no done pulse.
- Registers:
  - shreg[31:0] and cur_last hold the word in flight.
  - hold[31:0], hold_last and hold_valid form the one-entry buffer.
  - bit_idx[4:0] and sample_cnt[15:0] are counters.
- s_axis_tready = !hold_valid in SEND, 1 in IDLE. Handshake = tvalid & tready.
- A handshake with tkeep != 4'hF is consumed and discarded: not transmitted, not counted, its tlast ignored.
- IDLE:
  - ftw_valid = 0; ftw holds its last value.
  - On a valid handshake (tkeep = 4'hF): shreg <= tdata, cur_last <= tlast, bit_idx <= 31, sample_cnt <= 0, state <= SEND.
- SEND:
  - ftw_valid = 1; bit_out = shreg[31]; ftw = shreg[31] ? FTW1 : FTW0.
  - These are decoded from registered state; the first bit appears the clock after the load edge.
  - A valid handshake while hold is empty and the word is not ending loads hold and sets hold_valid.
  - sample_en with sample_cnt < SAMPLES_PER_BIT-1: sample_cnt + 1.
  - sample_en with sample_cnt = SAMPLES_PER_BIT-1: sample_cnt <= 0, then:
    - if bit_idx != 0: shreg <<= 1, bit_idx - 1;
    - if bit_idx = 0 (end of word): tx_pkt_done <= 1, tx_last <= cur_last, word_cnt + 1, then:
      - if hold_valid: shreg <= hold, cur_last <= hold_last, hold_valid <= 0, bit_idx <= 31; stay in SEND.
      - else if a valid handshake occurs this same cycle: load shreg directly from s_axis (bypass); stay in SEND.
      - else: state <= IDLE; ftw_valid drops on the next clock.
- Result: no sample_en is lost at word boundaries, and consecutive words produce a continuous symbol stream.
- sample_en in IDLE is ignored. sample_en never stalls on the slave interface.
- tx_pkt_done and tx_last are registered single-cycle pulses, low otherwise.
- Handshake rules:
  - tdata, tkeep and tlast are sampled only on the handshake edge.
  - Upstream may hold tvalid high across tready = 0 with no loss or duplication.

Test Plan (SAMPLES_PER_BIT=4, sample_en every 2nd clock):
1. Single word 32'hA5000000, tlast=1 -> bit_out sequence 1,0,1,0,0,1,0,1 then 24 zeros, each held 4 strobes; ftw alternates FTW1/FTW0 accordingly; after 128 strobes tx_pkt_done=tx_last=1 for one clock, word_cnt=1, ftw_valid=0 next clock.
2. Three words streamed with tvalid held high -> s_axis_tready low while hold is full; ftw_valid stays high for 384 consecutive strobes; three tx_pkt_done pulses 128 strobes apart; tx_last only on the third; word_cnt=3.
3. Word offered on the exact cycle of the final strobe with hold empty -> bypass load, no IDLE cycle, next word's MSB appears the following clock.
4. tkeep=4'h7 word followed by a 4'hF word 32'hFFFFFFFF -> first word consumed, no ftw_valid, no pulse; second transmits all FTW1; word_cnt=1.
5. Reset asserted at bit 10 of a word with hold full -> all outputs 0 immediately; after release, IDLE with tready=1, no tx_pkt_done; the next word transmits from bit 31.
6. word_cnt preloaded via 65535 transmitted words (or forced) -> next completion wraps word_cnt to 0.

Source files
------------

// File: rtl/fsk_bit_scheduler_if.sv
// ============================================================================
// Module   : fsk_bit_scheduler_if
// Purpose  : 32-bit AXI4-Stream word channel feeding the FSK bit scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fsk_bit_scheduler_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/fsk_bit_scheduler.sv
// ============================================================================
// Module   : fsk_bit_scheduler
// Purpose  : Serialises 32-bit stream words MSB-first into 2-FSK tuning words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsk_bit_scheduler #(
    parameter int          SAMPLES_PER_BIT = 64,
    parameter logic [31:0] FTW0            = 32'h0147AE14,
    parameter logic [31:0] FTW1            = 32'h028F5C29
) (
    input  wire logic             clk,
    input  wire logic             reset,
    fsk_bit_scheduler_if.slave    s_axis,
    input  wire logic             sample_en,
    output logic [31:0]           ftw,
    output logic                  ftw_valid,
    output logic                  bit_out,
    output logic                  tx_pkt_done,
    output logic                  tx_last,
    output logic [15:0]           word_cnt,
    output logic                  state
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [15:0] LAST_SAMPLE = 16'(SAMPLES_PER_BIT - 1);

    state_t      state_q,      state_d;
    logic [31:0] shreg_q,      shreg_d;
    logic        cur_last_q,   cur_last_d;
    logic [31:0] hold_q,       hold_d;
    logic        hold_last_q,  hold_last_d;
    logic        hold_valid_q, hold_valid_d;
    logic [4:0]  bit_idx_q,    bit_idx_d;
    logic [15:0] sample_cnt_q, sample_cnt_d;
    logic [31:0] ftw_q,        ftw_d;
    logic        ftw_valid_q,  ftw_valid_d;
    logic        bit_out_q,    bit_out_d;
    logic        done_q,       done_d;
    logic        last_q,       last_d;
    logic [15:0] word_cnt_q,   word_cnt_d;

    logic w_accept;
    logic w_good;
    logic w_sym_end;
    logic w_word_end;

    assign s_axis.tready = !reset && ((state_q == IDLE) || !hold_valid_q);

    assign w_accept   = s_axis.tvalid && s_axis.tready;
    assign w_good     = w_accept && (s_axis.tkeep == 4'hF);
    assign w_sym_end  = sample_en && (sample_cnt_q == LAST_SAMPLE);
    assign w_word_end = w_sym_end && (bit_idx_q == 5'd0);

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cur_last_d   = cur_last_q;
        hold_d       = hold_q;
        hold_last_d  = hold_last_q;
        hold_valid_d = hold_valid_q;
        bit_idx_d    = bit_idx_q;
        sample_cnt_d = sample_cnt_q;
        word_cnt_d   = word_cnt_q;
        done_d       = 1'b0;
        last_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_good) begin
                    shreg_d      = s_axis.tdata;
                    cur_last_d   = s_axis.tlast;
                    bit_idx_d    = 5'd31;
                    sample_cnt_d = 16'd0;
                    state_d      = SEND;
                end
            end
            SEND: begin
                // A word arriving on the final strobe bypasses hold (handled below)
                if (w_good && !hold_valid_q && !w_word_end) begin
                    hold_d       = s_axis.tdata;
                    hold_last_d  = s_axis.tlast;
                    hold_valid_d = 1'b1;
                end
                if (sample_en) begin
                    if (!w_sym_end) begin
                        sample_cnt_d = sample_cnt_q + 16'd1;
                    end else begin
                        sample_cnt_d = 16'd0;
                        if (bit_idx_q != 5'd0) begin
                            shreg_d   = {shreg_q[30:0], 1'b0};
                            bit_idx_d = bit_idx_q - 5'd1;
                        end else begin
                            done_d     = 1'b1;
                            last_d     = cur_last_q;
                            word_cnt_d = word_cnt_q + 16'd1;
                            if (hold_valid_q) begin
                                shreg_d      = hold_q;
                                cur_last_d   = hold_last_q;
                                hold_valid_d = 1'b0;
                                bit_idx_d    = 5'd31;
                            end else if (w_good) begin
                                shreg_d    = s_axis.tdata;
                                cur_last_d = s_axis.tlast;
                                bit_idx_d  = 5'd31;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Tuning word and bit hold their last value while idle
        ftw_valid_d = (state_d == SEND);
        ftw_d       = ftw_q;
        bit_out_d   = bit_out_q;
        if (state_d == SEND) begin
            bit_out_d = shreg_d[31];
            ftw_d     = shreg_d[31] ? FTW1 : FTW0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= 32'd0;
            cur_last_q   <= 1'b0;
            hold_q       <= 32'd0;
            hold_last_q  <= 1'b0;
            hold_valid_q <= 1'b0;
            bit_idx_q    <= 5'd0;
            sample_cnt_q <= 16'd0;
            ftw_q        <= 32'd0;
            ftw_valid_q  <= 1'b0;
            bit_out_q    <= 1'b0;
            done_q       <= 1'b0;
            last_q       <= 1'b0;
            word_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cur_last_q   <= cur_last_d;
            hold_q       <= hold_d;
            hold_last_q  <= hold_last_d;
            hold_valid_q <= hold_valid_d;
            bit_idx_q    <= bit_idx_d;
            sample_cnt_q <= sample_cnt_d;
            ftw_q        <= ftw_d;
            ftw_valid_q  <= ftw_valid_d;
            bit_out_q    <= bit_out_d;
            done_q       <= done_d;
            last_q       <= last_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign ftw         = ftw_q;
    assign ftw_valid   = ftw_valid_q;
    assign bit_out     = bit_out_q;
    assign tx_pkt_done = done_q;
    assign tx_last     = last_q;
    assign word_cnt    = word_cnt_q;
    assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_fsk_bit_scheduler.sv
// ============================================================================
// Module   : tb_fsk_bit_scheduler
// Purpose  : Directed self-checking bench for fsk_bit_scheduler (4 strobes/bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsk_bit_scheduler;

    localparam int          SPB = 4;
    localparam logic [31:0] F0  = 32'h0147AE14;
    localparam logic [31:0] F1  = 32'h028F5C29;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en;
    logic [31:0] ftw;
    logic        ftw_valid;
    logic        bit_out;
    logic        tx_pkt_done;
    logic        tx_last;
    logic [15:0] word_cnt;
    logic        state;

    fsk_bit_scheduler_if axis ();

    fsk_bit_scheduler #(
        .SAMPLES_PER_BIT (SPB),
        .FTW0            (F0),
        .FTW1            (F1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_axis      (axis),
        .sample_en   (sample_en),
        .ftw         (ftw),
        .ftw_valid   (ftw_valid),
        .bit_out     (bit_out),
        .tx_pkt_done (tx_pkt_done),
        .tx_last     (tx_last),
        .word_cnt    (word_cnt),
        .state       (state)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    bit          se_run = 1'b0;
    bit          mon_on = 1'b0;
    int          strobes;
    int          lowcnt;
    int          stall_cnt;
    logic        bits_q [$];
    logic [31:0] ftws_q [$];
    int          dones  [$];
    logic        lasts  [$];
    logic [15:0] wcs    [$];

    // One clock: record the strobe about to be consumed, then advance
    task automatic step();
        if (sample_en && ftw_valid) begin
            strobes++;
            bits_q.push_back(bit_out);
            ftws_q.push_back(ftw);
        end
        if (mon_on && !ftw_valid) lowcnt++;
        if (axis.tvalid && !axis.tready) stall_cnt++;
        @(posedge clk);
        #1;
        if (tx_pkt_done) begin
            dones.push_back(strobes);
            lasts.push_back(tx_last);
            wcs.push_back(word_cnt);
        end
        if (se_run) sample_en = ~sample_en;
        else        sample_en = 1'b0;
    endtask

    task automatic clear_mon();
        strobes = 0; lowcnt = 0; stall_cnt = 0;
        bits_q.delete(); ftws_q.delete();
        dones.delete(); lasts.delete(); wcs.delete();
    endtask

    task automatic push_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        bit ok;
        bit hs;
        ok = 1'b0;
        axis.tdata = d; axis.tkeep = k; axis.tlast = l; axis.tvalid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            hs = axis.tready;
            step();
            if (hs) begin ok = 1'b1; break; end
        end
        axis.tvalid = 1'b0;
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout: handshake=%0b required=1", ok);
        end
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 4000 && dones.size() < n; i++) step();
        checks++;
        if (dones.size() < n) begin
            errors++;
            $display("FAIL done_timeout: pulses=%0d required=%0d", dones.size(), n);
        end
    endtask

    // Mismatching strobes against words w0,w1,w2 sent back to back, 4 strobes per bit
    function automatic int bad_bits(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [31:0] w;
        logic        e;
        int          bad;
        bad = 0;
        for (int k = 0; k < bits_q.size(); k++) begin
            w = (k / 128 == 0) ? w0 : ((k / 128 == 1) ? w1 : w2);
            e = w[31 - (k % 128) / SPB];
            if (bits_q[k] !== e || ftws_q[k] !== (e ? F1 : F0)) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        #2;
        checks++; if (axis.tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got=%0b exp=0", axis.tready); end
        checks++; if (ftw_valid !== 1'b0) begin errors++; $display("FAIL rst_ftw_valid: got=%0b exp=0", ftw_valid); end
        checks++; if (ftw !== 32'd0) begin errors++; $display("FAIL rst_ftw: got=%h exp=0", ftw); end
        checks++; if ({bit_out, tx_pkt_done, tx_last, state} !== 4'b0) begin errors++; $display("FAIL rst_flags: got=%b exp=0000", {bit_out, tx_pkt_done, tx_last, state}); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL rst_word_cnt: got=%0d exp=0", word_cnt); end
        step(); step();
        reset = 1'b0;
        se_run = 1'b1;
        #1;
        checks++; if (axis.tready !== 1'b1) begin errors++; $display("FAIL idle_tready: got=%0b exp=1", axis.tready); end
    endtask

    task automatic test_single_word();
        clear_mon();
        push_word(32'hA5000000, 4'hF, 1'b1);
        checks++; if (bit_out !== 1'b1 || ftw !== F1 || ftw_valid !== 1'b1) begin errors++; $display("FAIL first_bit: bit=%0b ftw=%h fv=%0b exp 1/%h/1", bit_out, ftw, ftw_valid, F1); end
        wait_done(1);
        checks++; if (bits_q.size() !== 128) begin errors++; $display("FAIL t1_strobes: got=%0d exp=128", bits_q.size()); end
        checks++; if (bad_bits(32'hA5000000, 32'd0, 32'd0) !== 0) begin errors++; $display("FAIL t1_bits: bad=%0d exp=0", bad_bits(32'hA5000000, 32'd0, 32'd0)); end
        checks++; if (dones.size() > 0 && (dones[0] !== 128 || lasts[0] !== 1'b1 || wcs[0] !== 16'd1)) begin errors++; $display("FAIL t1_done: at=%0d last=%0b wc=%0d exp 128/1/1", dones[0], lasts[0], wcs[0]); end
        checks++; if (ftw_valid !== 1'b0 || state !== 1'b0) begin errors++; $display("FAIL t1_idle: fv=%0b st=%0b exp 0/0", ftw_valid, state); end
        step();
        checks++; if (tx_pkt_done !== 1'b0 || tx_last !== 1'b0) begin errors++; $display("FAIL t1_pulse_width: done=%0b last=%0b exp 0/0", tx_pkt_done, tx_last); end
        checks++; if (ftw !== F0) begin errors++; $display("FAIL t1_ftw_hold: got=%h exp=%h", ftw, F0); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        push_word(32'h12345678, 4'hF, 1'b0);
        mon_on = 1'b1;
        push_word(32'h9ABCDEF0, 4'hF, 1'b0);
        push_word(32'h0F0F00FF, 4'hF, 1'b1);
        wait_done(3);
        mon_on = 1'b0;
        checks++; if (stall_cnt == 0) begin errors++; $display("FAIL t2_stall: stalled_cycles=%0d exp>0", stall_cnt); end
        checks++; if (lowcnt !== 0) begin errors++; $display("FAIL t2_gap: ftw_valid_low=%0d exp=0", lowcnt); end
        checks++; if (bits_q.size() !== 384 || bad_bits(32'h12345678, 32'h9ABCDEF0, 32'h0F0F00FF) !== 0) begin errors++; $display("FAIL t2_bits: n=%0d bad=%0d exp 384/0", bits_q.size(), bad_bits(32'h12345678, 32'h9ABCDEF0, 32'h0F0F00FF)); end
        checks++; if (dones.size() == 3 && (dones[0] !== 128 || dones[1] !== 256 || dones[2] !== 384)) begin errors++; $display("FAIL t2_done_at: %0d %0d %0d exp 128 256 384", dones[0], dones[1], dones[2]); end
        checks++; if (lasts.size() == 3 && {lasts[0], lasts[1], lasts[2]} !== 3'b001) begin errors++; $display("FAIL t2_last: got=%b exp=001", {lasts[0], lasts[1], lasts[2]}); end
        checks++; if (word_cnt !== 16'd4) begin errors++; $display("FAIL t2_word_cnt: got=%0d exp=4", word_cnt); end
    endtask

    task automatic test_bypass();
        bit found;
        clear_mon();
        found = 1'b0;
        push_word(32'h00000000, 4'hF, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            if (sample_en && strobes == 127) begin found = 1'b1; break; end
            step();
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL t3_final_strobe: found=%0b exp=1", found); end
        axis.tdata = 32'h80000001; axis.tkeep = 4'hF; axis.tlast = 1'b1; axis.tvalid = 1'b1;
        checks++; if (axis.tready !== 1'b1) begin errors++; $display("FAIL t3_tready: got=%0b exp=1", axis.tready); end
        step();
        axis.tvalid = 1'b0;
        checks++; if (tx_pkt_done !== 1'b1 || state !== 1'b1 || ftw_valid !== 1'b1) begin errors++; $display("FAIL t3_no_idle: done=%0b st=%0b fv=%0b exp 1/1/1", tx_pkt_done, state, ftw_valid); end
        checks++; if (bit_out !== 1'b1 || ftw !== F1) begin errors++; $display("FAIL t3_msb: bit=%0b ftw=%h exp 1/%h", bit_out, ftw, F1); end
        checks++; if (word_cnt !== 16'd5) begin errors++; $display("FAIL t3_wc1: got=%0d exp=5", word_cnt); end
        wait_done(2);
        checks++; if (bits_q.size() !== 256 || bad_bits(32'h00000000, 32'h80000001, 32'd0) !== 0) begin errors++; $display("FAIL t3_bits: n=%0d bad=%0d exp 256/0", bits_q.size(), bad_bits(32'h00000000, 32'h80000001, 32'd0)); end
        checks++; if (wcs.size() == 2 && (wcs[1] !== 16'd6 || lasts[1] !== 1'b1 || lasts[0] !== 1'b0)) begin errors++; $display("FAIL t3_done2: wc=%0d last=%0b%0b exp 6/01", wcs[1], lasts[0], lasts[1]); end
    endtask

    task automatic test_tkeep_discard();
        clear_mon();
        push_word(32'h12345678, 4'h7, 1'b1);
        checks++; if (state !== 1'b0 || ftw_valid !== 1'b0) begin errors++; $display("FAIL t4_discard: st=%0b fv=%0b exp 0/0", state, ftw_valid); end
        for (int i = 0; i < 20; i++) step();
        checks++; if (dones.size() !== 0 || bits_q.size() !== 0) begin errors++; $display("FAIL t4_no_tx: pulses=%0d strobes=%0d exp 0/0", dones.size(), bits_q.size()); end
        push_word(32'hFFFFFFFF, 4'hF, 1'b0);
        wait_done(1);
        checks++; if (bits_q.size() !== 128 || bad_bits(32'hFFFFFFFF, 32'd0, 32'd0) !== 0) begin errors++; $display("FAIL t4_bits: n=%0d bad=%0d exp 128/0", bits_q.size(), bad_bits(32'hFFFFFFFF, 32'd0, 32'd0)); end
        checks++; if (wcs.size() == 1 && (wcs[0] !== 16'd7 || lasts[0] !== 1'b0)) begin errors++; $display("FAIL t4_done: wc=%0d last=%0b exp 7/0", wcs[0], lasts[0]); end
    endtask

    task automatic test_reset_mid_word();
        clear_mon();
        push_word(32'hC3C3C3C3, 4'hF, 1'b0);
        push_word(32'h3C3C3C3C, 4'hF, 1'b1);
        for (int i = 0; i < 1000 && strobes < 84; i++) step();
        checks++; if (state !== 1'b1 || axis.tready !== 1'b0 || bit_out !== 1'b0) begin errors++; $display("FAIL t5_pre: st=%0b tready=%0b bit=%0b exp 1/0/0", state, axis.tready, bit_out); end
        reset = 1'b1;
        #1;
        checks++; if (ftw_valid !== 1'b0 || ftw !== 32'd0 || state !== 1'b0) begin errors++; $display("FAIL t5_async: fv=%0b ftw=%h st=%0b exp 0/0/0", ftw_valid, ftw, state); end
        checks++; if (word_cnt !== 16'd0 || axis.tready !== 1'b0 || tx_pkt_done !== 1'b0) begin errors++; $display("FAIL t5_async2: wc=%0d tready=%0b done=%0b exp 0/0/0", word_cnt, axis.tready, tx_pkt_done); end
        step(); step();
        reset = 1'b0;
        #1;
        checks++; if (axis.tready !== 1'b1 || state !== 1'b0) begin errors++; $display("FAIL t5_release: tready=%0b st=%0b exp 1/0", axis.tready, state); end
        clear_mon();
        for (int i = 0; i < 30; i++) step();
        checks++; if (dones.size() !== 0 || ftw_valid !== 1'b0) begin errors++; $display("FAIL t5_dropped: pulses=%0d fv=%0b exp 0/0", dones.size(), ftw_valid); end
        push_word(32'h80F0000F, 4'hF, 1'b1);
        checks++; if (bit_out !== 1'b1) begin errors++; $display("FAIL t5_msb: got=%0b exp=1", bit_out); end
        wait_done(1);
        checks++; if (bits_q.size() !== 128 || bad_bits(32'h80F0000F, 32'd0, 32'd0) !== 0) begin errors++; $display("FAIL t5_bits: n=%0d bad=%0d exp 128/0", bits_q.size(), bad_bits(32'h80F0000F, 32'd0, 32'd0)); end
        checks++; if (wcs.size() == 1 && (wcs[0] !== 16'd1 || lasts[0] !== 1'b1)) begin errors++; $display("FAIL t5_done: wc=%0d last=%0b exp 1/1", wcs[0], lasts[0]); end
    endtask

    task automatic test_word_cnt_wrap();
        clear_mon();
        force dut.word_cnt_q = 16'hFFFF;
        #1;
        release dut.word_cnt_q;
        #1;
        checks++; if (word_cnt !== 16'hFFFF) begin errors++; $display("FAIL t6_preload: got=%h exp=ffff", word_cnt); end
        push_word(32'h00000001, 4'hF, 1'b1);
        wait_done(1);
        checks++; if (wcs.size() == 1 && (wcs[0] !== 16'd0 || lasts[0] !== 1'b1)) begin errors++; $display("FAIL t6_wrap: wc=%h last=%0b exp 0000/1", wcs[0], lasts[0]); end
    endtask

    initial begin
        reset       = 1'b1;
        sample_en   = 1'b0;
        axis.tdata  = 32'd0;
        axis.tkeep  = 4'h0;
        axis.tlast  = 1'b0;
        axis.tvalid = 1'b0;
        clear_mon();
        test_reset();
        test_single_word();
        test_back_to_back();
        test_bypass();
        test_tkeep_discard();
        test_reset_mid_word();
        test_word_cnt_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
